// File: rtl/batpu_pkg.sv
// Shared widths, reset PC and fetch-path types for the instruction fetch stage.
package batpu_pkg;

    localparam int ADDR_W = 10;
    localparam int INST_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // State of the single outstanding cache request slot.
    typedef enum logic {
        SLOT_IDLE,
        SLOT_WAIT
    } slot_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with synchronous flush; head entry reads as zero when empty.
module fetch_fifo
    import batpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  fetch_entry_t            push_entry,
    input  logic                    pop,
    output fetch_entry_t            head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem_reg [DEPTH];
    logic [PW:0]    wr_ptr_reg;
    logic [PW:0]    rd_ptr_reg;

    // The extra wrap bit makes full (count == DEPTH) distinct from empty.
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign head  = (count != '0) ? mem_reg[rd_ptr_reg[PW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg[PW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues to the cache with credit-based flow control,
// tracks the single in-flight request and squashes it on branch redirects.
module fetch_unit
    import batpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    output logic               ic_req,
    output logic [ADDR_W-1:0]  ic_addr,
    input  logic [INST_W-1:0]  ic_inst,
    input  logic               ic_busy,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INST_W-1:0]  dec_inst,
    output logic [ADDR_W-1:0]  dec_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    slot_state_t        state_reg;
    logic               squash_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  inflight_pc_reg;

    logic               active;
    logic               inflight;
    logic               resp;
    logic               pop;
    logic               push;
    logic               flush;
    logic               issue;
    logic [CW:0]        credit;
    logic [CW-1:0]      count;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;

    assign active   = clk_en && !rst;
    assign inflight = (state_reg == SLOT_WAIT);
    assign resp     = inflight && !ic_busy;

    assign dec_valid = active && (count != '0) && !redirect;
    assign pop       = dec_valid && dec_ready;

    // Slots committed after this edge: buffered + in flight - leaving now.
    // Counting the popped entry is what allows one issue per cycle at full rate.
    assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue  = active && !redirect && !ic_busy && (credit < (CW+1)'(DEPTH));

    assign push  = active && !redirect && resp && !squash_reg;
    assign flush = active && redirect;

    assign ic_req  = issue || (active && inflight && ic_busy);
    assign ic_addr = (inflight && ic_busy) ? inflight_pc_reg : pc_reg;

    assign push_entry = '{pc: inflight_pc_reg, inst: ic_inst};
    assign dec_inst   = head.inst;
    assign dec_pc     = head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= SLOT_IDLE;
            squash_reg      <= 1'b0;
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= RESET_PC;
        end else if (clk_en) begin
            if (redirect) begin
                pc_reg <= redirect_pc;
                // A fill still running must be waited out; a response landing now is just dropped.
                if (inflight && ic_busy) begin
                    squash_reg <= 1'b1;
                end else begin
                    state_reg  <= SLOT_IDLE;
                    squash_reg <= 1'b0;
                end
            end else begin
                if (resp) begin
                    squash_reg <= 1'b0;
                end
                if (issue) begin
                    inflight_pc_reg <= pc_reg;
                    pc_reg          <= pc_reg + ADDR_W'(1);
                end
                case (state_reg)
                    SLOT_IDLE: begin
                        if (issue) begin
                            state_reg <= SLOT_WAIT;
                        end
                    end
                    SLOT_WAIT: begin
                        if (!ic_busy) begin
                            state_reg <= issue ? SLOT_WAIT : SLOT_IDLE;
                        end
                    end
                    default: state_reg <= SLOT_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural cache with registered read, scoreboard of expected PCs.
module tb_fetch_unit;
    import batpu_pkg::*;

    localparam int TB_DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_en;
    logic               ic_req;
    logic [ADDR_W-1:0]  ic_addr;
    logic [INST_W-1:0]  ic_inst = '0;
    logic               ic_busy;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               dec_valid;
    logic               dec_ready;
    logic [INST_W-1:0]  dec_inst;
    logic [ADDR_W-1:0]  dec_pc;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    logic [ADDR_W-1:0]  exp_q [$];
    logic [ADDR_W-1:0]  nxt;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH (TB_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_inst     (ic_inst),
        .ic_busy     (ic_busy),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc)
    );

    function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[5:0], a} ^ 16'hA55A;
    endfunction

    // Cache model: address accepted when requested and not busy, data held until the next accept.
    always @(posedge clk) begin
        if (ic_req && !ic_busy) begin
            ic_inst <= mem_word(ic_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic sb_load(input logic [ADDR_W-1:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(start + ADDR_W'(i));
        end
    endtask

    // Wait to the mid-cycle sample point and retire any handshake against the scoreboard.
    task automatic settle();
        logic [ADDR_W-1:0] e;
        @(negedge clk);
        if (dec_valid && dec_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dec_pc", 32'(dec_pc), 32'(e));
                chk("dec_inst", 32'(dec_inst), 32'(mem_word(e)));
                $display("[TB] deliver pc=%03h inst=%04h", dec_pc, dec_inst);
            end
        end
        chk("fifo_bound", 32'(dut.u_fifo.count <= TB_DEPTH), 32'd1);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_chk(input logic req_e, input logic [ADDR_W-1:0] addr_e, input logic valid_e);
        settle();
        chk("ic_req", 32'(ic_req), 32'(req_e));
        chk("ic_addr", 32'(ic_addr), 32'(addr_e));
        chk("dec_valid", 32'(dec_valid), 32'(valid_e));
    endtask

    task automatic steady(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_chk(1'b1, nxt, 1'b1);
            advance();
            nxt = nxt + ADDR_W'(1);
        end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; ic_busy = 1'b0;
        redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b1;

        // Reset holds outputs quiet even with every issue condition otherwise true.
        settle();
        chk("rst_ic_req", 32'(ic_req), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_pc", 32'(dec_pc), 32'd0);
        chk("rst_dec_inst", 32'(dec_inst), 32'd0);
        advance();
        settle();
        advance();

        // All hits from reset.
        rst = 1'b0;
        sb_load(RESET_PC, 32);
        for (int c = 0; c < 6; c++) begin
            cyc_chk(1'b1, ADDR_W'(c), c >= 2);
            advance();
        end

        // Miss on pc 5: 17 busy cycles.
        ic_busy = 1'b1;
        for (int b = 0; b < 17; b++) begin
            settle();
            chk("miss_addr", 32'(ic_addr), 32'h5);
            chk("miss_req", 32'(ic_req), 32'd1);
            if (b >= 1) begin
                chk("miss_valid", 32'(dec_valid), 32'd0);
                chk("empty_pc", 32'(dec_pc), 32'd0);
            end
            advance();
        end
        ic_busy = 1'b0;
        cyc_chk(1'b1, ADDR_W'(6), 1'b0);
        advance();
        nxt = ADDR_W'(7);
        steady(4);

        // Decode backpressure for 10 cycles.
        dec_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            cyc_chk(1'b0, nxt, 1'b1);
            chk("stall_head", 32'(dec_pc), 32'(nxt - ADDR_W'(2)));
            advance();
        end
        dec_ready = 1'b1;
        steady(4);

        // Redirect with hits: buffered and in-flight entries never presented.
        sb_load(ADDR_W'('h200), 16);
        redirect = 1'b1; redirect_pc = ADDR_W'('h200);
        settle();
        chk("redir_valid", 32'(dec_valid), 32'd0);
        chk("redir_req", 32'(ic_req), 32'd0);
        advance();
        redirect = 1'b0;
        nxt = ADDR_W'('h200);
        for (int i = 0; i < 2; i++) begin
            cyc_chk(1'b1, nxt, 1'b0);
            advance();
            nxt = nxt + ADDR_W'(1);
        end
        settle();
        chk("redir_first_pc", 32'(dec_pc), 32'h200);
        chk("redir_first_valid", 32'(dec_valid), 32'd1);
        advance();
        nxt = nxt + ADDR_W'(1);
        steady(4);

        // Redirect during a miss fill on 0x206.
        ic_busy = 1'b1;
        settle();
        chk("fill_addr", 32'(ic_addr), 32'h206);
        chk("fill_req", 32'(ic_req), 32'd1);
        advance();
        sb_load(ADDR_W'('h010), 16);
        redirect = 1'b1; redirect_pc = ADDR_W'('h010);
        cyc_chk(1'b1, ADDR_W'('h206), 1'b0);
        advance();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc_chk(1'b1, ADDR_W'('h206), 1'b0);
            advance();
        end
        ic_busy = 1'b0;
        cyc_chk(1'b1, ADDR_W'('h010), 1'b0);
        advance();
        cyc_chk(1'b1, ADDR_W'('h011), 1'b0);
        advance();
        settle();
        chk("squash_first_pc", 32'(dec_pc), 32'h010);
        chk("squash_first_valid", 32'(dec_valid), 32'd1);
        advance();
        nxt = ADDR_W'('h013);
        steady(2);

        // PC wrap across 1023, then a 3-cycle clock-enable freeze.
        sb_load(ADDR_W'('h3FE), 16);
        redirect = 1'b1; redirect_pc = ADDR_W'('h3FE);
        settle();
        chk("wrap_redir_valid", 32'(dec_valid), 32'd0);
        advance();
        redirect = 1'b0;
        nxt = ADDR_W'('h3FE);
        for (int i = 0; i < 2; i++) begin
            cyc_chk(1'b1, nxt, 1'b0);
            advance();
            nxt = nxt + ADDR_W'(1);
        end
        steady(4);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc_chk(1'b0, nxt, 1'b0);
            chk("freeze_pc", 32'(dec_pc), 32'(exp_q[0]));
            chk("freeze_inst", 32'(dec_inst), 32'(mem_word(exp_q[0])));
            advance();
        end
        clk_en = 1'b1;
        steady(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
